// File: rtl/fluxo_dados_contador_param_if.sv
// ============================================================================
// fluxo_dados_contador_param_if
// Control, switch and status bundle between the control unit and the datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fluxo_dados_contador_param_if #(
  parameter int N = 4
);
  logic         carrega;
  logic         registra;
  logic         conta;
  logic         sentido;
  logic [N-1:0] chaves;
  logic         menor;
  logic         maior;
  logic         igual;
  logic         igual_pulso;
  logic         fim;
  logic         estouro;
  logic [N-1:0] db_contagem;
  logic [N-1:0] db_referencia;

  modport master (
    output carrega, registra, conta, sentido, chaves,
    input  menor, maior, igual, igual_pulso, fim, estouro,
           db_contagem, db_referencia
  );

  modport slave (
    input  carrega, registra, conta, sentido, chaves,
    output menor, maior, igual, igual_pulso, fim, estouro,
           db_contagem, db_referencia
  );
endinterface

`default_nettype wire

// File: rtl/fluxo_dados_contador_param.sv
// ============================================================================
// fluxo_dados_contador_param
// N-bit modulo-MODULO up/down counter with saturating loads, reference register,
// magnitude comparator, sticky wrap flag and single-cycle equality pulse.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fluxo_dados_contador_param #(
  parameter int N      = 4,
  parameter int MODULO = 16
) (
  input  wire                              clock,
  input  wire                              zera_n,
  fluxo_dados_contador_param_if.slave      bus
);

  localparam logic [N:0]   MOD_EXT = (N+1)'(MODULO);
  localparam logic [N-1:0] MAX_C   = N'(MODULO - 1);

  logic [N-1:0] contagem;
  logic [N-1:0] referencia;
  logic         estouro;
  logic         igual_d;

  logic [N-1:0] contagem_next;
  logic         wrap;
  logic [N-1:0] chaves_sat;
  logic         igual;

  // Switch values at or beyond the modulus clamp to the last valid count.
  always_comb begin
    chaves_sat = bus.chaves;
    if ({1'b0, bus.chaves} >= MOD_EXT) begin
      chaves_sat = MAX_C;
    end
  end

  always_comb begin
    contagem_next = contagem;
    wrap          = 1'b0;
    if (bus.carrega) begin
      contagem_next = chaves_sat;
    end else if (bus.conta) begin
      if (!bus.sentido) begin
        if (contagem == MAX_C) begin
          contagem_next = '0;
          wrap          = 1'b1;
        end else begin
          contagem_next = contagem + 1'b1;
        end
      end else begin
        if (contagem == '0) begin
          contagem_next = MAX_C;
          wrap          = 1'b1;
        end else begin
          contagem_next = contagem - 1'b1;
        end
      end
    end
  end

  assign igual = (contagem == referencia);

  // igual_d starts at 1 so the equal state right after reset is not an edge.
  always_ff @(posedge clock) begin
    if (!zera_n) begin
      contagem   <= '0;
      referencia <= '0;
      estouro    <= 1'b0;
      igual_d    <= 1'b1;
    end else begin
      contagem <= contagem_next;
      if (bus.registra) begin
        referencia <= chaves_sat;
      end
      if (wrap) begin
        estouro <= 1'b1;
      end
      igual_d <= igual;
    end
  end

  assign bus.igual         = igual;
  assign bus.menor         = (contagem < referencia);
  assign bus.maior         = (contagem > referencia);
  assign bus.igual_pulso   = igual & ~igual_d;
  assign bus.fim           = bus.sentido ? (contagem == '0) : (contagem == MAX_C);
  assign bus.estouro       = estouro;
  assign bus.db_contagem   = contagem;
  assign bus.db_referencia = referencia;

endmodule

`default_nettype wire
